// File: rtl/ahb_lite_bram_ws_if.sv
`default_nettype none
// ============================================================================
// Module  : ahb_lite_bram_ws_if
// Purpose : AHB-Lite bus bundle between a master/decoder and the BRAM slave.
// Ports   : HADDR/HBURST/HMASTLOCK/HPROT/HSEL/HSIZE/HTRANS/HWDATA/HWRITE/
//           HREADY/SI_Endian  -> slave
//           HRDATA/HREADYOUT/HRESP -> master
// Revision: 1.0 - initial release
// ============================================================================
interface ahb_lite_bram_ws_if #(
  parameter int HADDR_WIDTH = 17,
  parameter int HDATA_WIDTH = 32
);
  logic [HADDR_WIDTH-1:0] HADDR;
  logic [2:0]             HBURST;
  logic                   HMASTLOCK;
  logic [3:0]             HPROT;
  logic                   HSEL;
  logic [2:0]             HSIZE;
  logic [1:0]             HTRANS;
  logic [HDATA_WIDTH-1:0] HWDATA;
  logic                   HWRITE;
  logic                   HREADY;
  logic [HDATA_WIDTH-1:0] HRDATA;
  logic                   HREADYOUT;
  logic                   HRESP;
  logic                   SI_Endian;

  modport master (
    output HADDR, HBURST, HMASTLOCK, HPROT, HSEL, HSIZE, HTRANS,
           HWDATA, HWRITE, HREADY, SI_Endian,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HADDR, HBURST, HMASTLOCK, HPROT, HSEL, HSIZE, HTRANS,
           HWDATA, HWRITE, HREADY, SI_Endian,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_bram_ws.sv
`default_nettype none
// ============================================================================
// Module  : ahb_lite_bram_ws
// Purpose : AHB-Lite slave around an inferred simple-dual-port block RAM with
//           byte-lane writes, 0..3 read wait states and read-after-write
//           forwarding. Writes are always zero-wait.
// Ports   : HCLK     - clock, rising edge
//           HRESETn  - asynchronous active-low reset
//           bus      - ahb_lite_bram_ws_if.slave (AHB-Lite signals)
// Options : AHB_BRAM_ERROR_EN - when defined, misaligned or over-wide
//           transfers get a two-cycle ERROR response and no memory access;
//           otherwise they act as full-word accesses at the aligned address.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_lite_bram_ws #(
  parameter int HADDR_WIDTH = 17,
  parameter int HDATA_WIDTH = 32,
  parameter int WAIT_STATES = 0,
  parameter     INIT_RMEMH  = "",
  parameter int MADDR_WIDTH = HADDR_WIDTH - $clog2(HDATA_WIDTH/8)
) (
  input wire logic          HCLK,
  input wire logic          HRESETn,
  ahb_lite_bram_ws_if.slave bus
);

  localparam int         NBYTES = HDATA_WIDTH / 8;
  localparam int         OFFW   = $clog2(NBYTES);
  localparam int         MDEPTH = 1 << MADDR_WIDTH;
  localparam logic [1:0] WS     = 2'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RWAIT = 2'd1,
    S_ERR1  = 2'd2,
    S_ERR2  = 2'd3
  } state_e;

  state_e                 state_q;
  logic [1:0]             cnt_q;
  logic                   hreadyout_q;
  logic                   hresp_q;
  logic                   wr_pend_q;
  logic [MADDR_WIDTH-1:0] wr_addr_q;
  logic [NBYTES-1:0]      wr_mask_q;
  logic [HDATA_WIDTH-1:0] rd_raw_q;
  logic [NBYTES-1:0]      fwd_mask_q;
  logic [HDATA_WIDTH-1:0] fwd_data_q;

  logic [HDATA_WIDTH-1:0] mem_q [MDEPTH];

  logic [MADDR_WIDTH-1:0] waddr_d;
  logic                   misalign_d;
  logic                   too_wide_d;
  logic                   bad_d;
  logic                   err_d;
  logic                   accept_d;
  logic                   rd_en_d;
  logic                   fwd_d;
  logic [NBYTES-1:0]      mask_d;
  logic [HDATA_WIDTH-1:0] rd_merged_d;

  // Sideband signals this slave deliberately ignores.
  logic unused_ok;
  assign unused_ok = ^{bus.HBURST, bus.HMASTLOCK, bus.HPROT, bus.SI_Endian,
                       bus.HTRANS[0]};

  // --------------------------------------------------------------------------
  // Address-phase decode
  // --------------------------------------------------------------------------
  assign waddr_d = bus.HADDR[OFFW +: MADDR_WIDTH];

  always_comb begin
    misalign_d = 1'b0;
    case (bus.HSIZE)
      3'd1:    misalign_d = bus.HADDR[0];
      3'd2:    misalign_d = |bus.HADDR[1:0];
      3'd3:    misalign_d = |bus.HADDR[2:0];
      default: misalign_d = 1'b0;
    endcase
  end

  assign too_wide_d = int'(bus.HSIZE) > OFFW;
  assign bad_d      = misalign_d | too_wide_d;

  // Lane k is enabled when it lies in [offset, offset + 2**HSIZE). A bad
  // transfer that is not errored falls back to the whole aligned word.
  always_comb begin
    int lo;
    int nb;
    lo     = int'(bus.HADDR[OFFW-1:0]);
    nb     = 1 << bus.HSIZE;
    mask_d = '0;
    for (int k = 0; k < NBYTES; k++) begin
      mask_d[k] = bad_d | ((k >= lo) && (k < lo + nb));
    end
  end

`ifdef AHB_BRAM_ERROR_EN
  assign err_d = bad_d;
`else
  assign err_d = 1'b0;
`endif

  // New address phases are only taken when the previous data phase ends
  // with HREADYOUT high, i.e. from IDLE or from the second error cycle.
  assign accept_d = bus.HSEL & bus.HREADY & bus.HTRANS[1] &
                    ((state_q == S_IDLE) | (state_q == S_ERR2));
  assign rd_en_d  = accept_d & ~err_d & ~bus.HWRITE;

  // The write whose data phase is ending now commits at this same edge; a
  // read of that word must see it, so its bytes are captured for a merge.
  assign fwd_d = wr_pend_q & (wr_addr_q == waddr_d);

  always_comb begin
    rd_merged_d = rd_raw_q;
    for (int k = 0; k < NBYTES; k++) begin
      if (fwd_mask_q[k]) rd_merged_d[8*k +: 8] = fwd_data_q[8*k +: 8];
    end
  end

  // --------------------------------------------------------------------------
  // Memory array: write port only; contents survive reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK) begin
    if (wr_pend_q) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (wr_mask_q[k]) mem_q[wr_addr_q][8*k +: 8] <= bus.HWDATA[8*k +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM, pending write and synchronous read port
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_mask_q   <= '0;
      rd_raw_q    <= '0;
      fwd_mask_q  <= '0;
      fwd_data_q  <= '0;
    end else begin
      wr_pend_q <= 1'b0;
      if (rd_en_d) begin
        rd_raw_q   <= mem_q[waddr_d];
        fwd_mask_q <= fwd_d ? wr_mask_q : '0;
        fwd_data_q <= bus.HWDATA;
      end
      case (state_q)
        S_RWAIT: begin
          if (cnt_q == 2'd1) begin
            state_q     <= S_IDLE;
            hreadyout_q <= 1'b1;
          end
          cnt_q <= cnt_q - 2'd1;
        end
        S_ERR1: begin
          state_q     <= S_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b0;
          if (accept_d) begin
            if (err_d) begin
              state_q     <= S_ERR1;
              hreadyout_q <= 1'b0;
              hresp_q     <= 1'b1;
            end else if (bus.HWRITE) begin
              wr_pend_q <= 1'b1;
              wr_addr_q <= waddr_d;
              wr_mask_q <= mask_d;
            end else if (WS != 2'd0) begin
              state_q     <= S_RWAIT;
              cnt_q       <= WS;
              hreadyout_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Read data: with no wait states the read register itself is presented;
  // otherwise a held output register is loaded as the last wait cycle ends.
  // --------------------------------------------------------------------------
  if (WAIT_STATES == 0) begin : g_rdata_direct
    assign bus.HRDATA = rd_merged_d;
  end else begin : g_rdata_held
    logic [HDATA_WIDTH-1:0] hrdata_q;
    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
        hrdata_q <= '0;
      end else if ((state_q == S_RWAIT) && (cnt_q == 2'd1)) begin
        hrdata_q <= rd_merged_d;
      end
    end
    assign bus.HRDATA = hrdata_q;
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_bram_ws.sv
`default_nettype none
// ============================================================================
// Module  : tb_ahb_lite_bram_ws
// Purpose : Self-checking bench for ahb_lite_bram_ws. Two instances share one
//           master: dut0 with no wait states, dut1 with two. A byte-addressed
//           reference memory predicts read data, wait cycles and responses.
// Options : AHB_BRAM_ERROR_EN changes the expected handling of misaligned
//           and over-wide transfers.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb_lite_bram_ws;
  localparam int AW = 17;
  localparam int DW = 32;

`ifdef AHB_BRAM_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ahb_lite_bram_ws_if #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW)) if0 ();
  ahb_lite_bram_ws_if #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW)) if1 ();

  ahb_lite_bram_ws #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW), .WAIT_STATES(0))
    dut0 (.HCLK(clk), .HRESETn(rst_n), .bus(if0));
  ahb_lite_bram_ws #(.HADDR_WIDTH(AW), .HDATA_WIDTH(DW), .WAIT_STATES(2))
    dut1 (.HCLK(clk), .HRESETn(rst_n), .bus(if1));

  // Shared master signals; phase selects which slave is addressed.
  logic [AW-1:0] haddr;
  logic [2:0]    hsize;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [DW-1:0] hwdata;
  logic          hsel;
  logic          phase;

  wire           bus_rdy   = phase ? if1.HREADYOUT : if0.HREADYOUT;
  wire           bus_resp  = phase ? if1.HRESP     : if0.HRESP;
  wire [DW-1:0]  bus_rdata = phase ? if1.HRDATA    : if0.HRDATA;

  assign if0.HADDR = haddr;   assign if1.HADDR = haddr;
  assign if0.HSIZE = hsize;   assign if1.HSIZE = hsize;
  assign if0.HTRANS = htrans; assign if1.HTRANS = htrans;
  assign if0.HWRITE = hwrite; assign if1.HWRITE = hwrite;
  assign if0.HWDATA = hwdata; assign if1.HWDATA = hwdata;
  assign if0.HSEL = hsel & ~phase;
  assign if1.HSEL = hsel & phase;
  assign if0.HREADY = bus_rdy; assign if1.HREADY = bus_rdy;
  assign if0.HBURST = 3'd1;   assign if1.HBURST = 3'd1;
  assign if0.HMASTLOCK = 1'b0; assign if1.HMASTLOCK = 1'b0;
  assign if0.HPROT = 4'h3;    assign if1.HPROT = 4'h3;
  assign if0.SI_Endian = 1'b0; assign if1.SI_Endian = 1'b0;

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: plain byte-addressed memory
  // --------------------------------------------------------------------------
  bit [7:0] refm [int];

  function automatic bit is_bad(input logic [AW-1:0] a, input logic [2:0] s);
    return (s > 3'd2) || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
    logic [31:0] w;
    int base;
    base = int'(a) & ~3;
    w = '0;
    for (int i = 0; i < 4; i++)
      if (refm.exists(base + i)) w[8*i +: 8] = refm[base + i];
    return w;
  endfunction

  // A byte at address b travels on lane b mod 4 of the data bus.
  function automatic void ref_write(input logic [AW-1:0] a, input logic [2:0] s,
                                    input logic [31:0] d);
    int base;
    if (is_bad(a, s)) begin
      base = int'(a) & ~3;
      for (int i = 0; i < 4; i++) refm[base + i] = d[8*i +: 8];
    end else begin
      for (int i = 0; i < (1 << s); i++) refm[int'(a) + i] = d[8*((int'(a) + i) % 4) +: 8];
    end
  endfunction

  // --------------------------------------------------------------------------
  // Pipelined master
  // --------------------------------------------------------------------------
  typedef struct {
    bit          valid;
    bit          sel;
    bit          write;
    logic [AW-1:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  op_t         q[$];
  logic [31:0] last_rd = '0;

  function automatic op_t mk(input bit w, input logic [AW-1:0] a,
                             input logic [2:0] s, input logic [31:0] d);
    op_t o;
    o.valid = 1'b1; o.sel = 1'b1; o.write = w; o.addr = a; o.size = s; o.wdata = d;
    return o;
  endfunction

  function automatic op_t rnd_op();
    op_t o;
    logic [AW-1:0] base;
    base    = ($urandom_range(0, 1) == 1) ? 17'h1FFC0 : 17'h00000;
    o.valid = $urandom_range(0, 99) < 85;
    o.sel   = $urandom_range(0, 9) != 0;
    o.write = 1'($urandom_range(0, 1));
    o.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
    o.addr  = base | AW'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0)
      o.addr = o.addr & AW'(~((32'd1 << o.size) - 32'd1));
    o.wdata = $urandom;
    return o;
  endfunction

  task automatic complete(input op_t dp, input int waits, input bit resp_w);
    bit err;
    int exp_w;
    if (!dp.sel) begin
      check("nosel_waits", waits, 0);
      check("nosel_resp", bus_resp, 0);
      return;
    end
    err   = ERR_EN && is_bad(dp.addr, dp.size);
    exp_w = err ? 1 : (dp.write ? 0 : (phase ? 2 : 0));
    check("waits", waits, exp_w);
    check("resp_wait", resp_w, err);
    check("resp_done", bus_resp, err);
    if (!err) begin
      if (dp.write) begin
        ref_write(dp.addr, dp.size, dp.wdata);
      end else begin
        check("rdata", bus_rdata, ref_read(dp.addr));
        last_rd = bus_rdata;
      end
    end
  endtask

  task automatic run_ops();
    op_t dp;
    op_t op;
    int  waits;
    bit  resp_w;
    dp = mk(1'b0, '0, 3'd0, '0);
    dp.valid = 1'b0;
    op = dp;
    q.push_back(op);
    while (q.size() > 0) begin
      op = q.pop_front();
      @(negedge clk);
      hwdata = (dp.valid && dp.write) ? dp.wdata : $urandom;
      waits  = 0;
      resp_w = 1'b0;
      while (!bus_rdy && waits < 20) begin
        resp_w |= bus_resp;
        waits++;
        @(negedge clk);
      end
      if (!bus_rdy) check("ready_timeout", bus_rdy, 1);
      if (dp.valid) complete(dp, waits, resp_w);
      haddr  = op.valid ? op.addr : AW'($urandom);
      hsize  = op.size;
      hwrite = op.write;
      htrans = op.valid ? {1'b1, 1'($urandom_range(0, 1))} : {1'b0, 1'($urandom_range(0, 1))};
      hsel   = op.valid ? op.sel : 1'($urandom_range(0, 1));
      dp = op;
    end
  endtask

  task automatic init_mem();
    refm.delete();
    for (int b = 0; b < 2; b++)
      for (int w = 0; w < 16; w++)
        q.push_back(mk(1'b1, (b == 1 ? 17'h1FFC0 : 17'h0) + AW'(w * 4), 3'd2, $urandom));
    run_ops();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   bus_rdy,   1);
    check({tag, "_resp"},  bus_resp,  0);
    check({tag, "_rdata"}, bus_rdata, 0);
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    haddr = '0; hsize = 3'd2; htrans = 2'b00; hwrite = 1'b0;
    hwdata = '0; hsel = 1'b0; phase = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset0");
    phase = 1'b1; #1;
    check_reset_outputs("reset1");
    phase = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_reset_outputs("idle0");

    // ---------------- no wait states ----------------
    init_mem();
    q.push_back(mk(1'b1, 17'h10, 3'd2, 32'h11223344));
    q.push_back(mk(1'b0, 17'h10, 3'd2, '0));
    run_ops();
    check("fwd_word", last_rd, 32'h11223344);

    q.push_back(mk(1'b1, 17'h13, 3'd0, 32'hAA5A5A5A));
    q.push_back(mk(1'b0, 17'h10, 3'd2, '0));
    run_ops();
    check("byte_merge", last_rd, 32'hAA223344);

    q.push_back(mk(1'b1, 17'h11, 3'd1, 32'h55667788));
    q.push_back(mk(1'b0, 17'h10, 3'd2, '0));
    run_ops();
    check("misaligned_half", last_rd, ERR_EN ? 32'hAA223344 : 32'h55667788);

    repeat (150) q.push_back(rnd_op());
    run_ops();

    // Reset during a write data phase must leave memory untouched.
    @(negedge clk);
    haddr = 17'h24; hsize = 3'd2; hwrite = 1'b1; htrans = 2'b10; hsel = 1'b1;
    @(negedge clk);
    hwdata = 32'hDEADBEEF; htrans = 2'b00; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(mk(1'b0, 17'h24, 3'd2, '0));
    run_ops();
    check("no_partial_write", last_rd, ref_read(17'h24));

    // ---------------- two wait states ----------------
    phase = 1'b1;
    init_mem();
    q.push_back(mk(1'b1, 17'h10, 3'd2, 32'h11223344));
    q.push_back(mk(1'b0, 17'h10, 3'd2, '0));
    run_ops();
    check("ws2_fwd_word", last_rd, 32'h11223344);

    repeat (150) q.push_back(rnd_op());
    run_ops();

    // Reset while the read is waiting releases the bus at once.
    @(negedge clk);
    haddr = 17'h10; hsize = 3'd2; hwrite = 1'b0; htrans = 2'b10; hsel = 1'b1;
    @(negedge clk);
    htrans = 2'b00;
    check("rwait_low", bus_rdy, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rwait_reset");
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back(mk(1'b0, 17'h10, 3'd2, '0));
    run_ops();
    check("after_reset_read", last_rd, ref_read(17'h10));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
